// File: rtl/bios_arb_pkg.sv
// -----------------------------------------------------------------------------
// bios_arb_pkg
// Shared definitions for the BIOS memory arbiter:
//   owner_t                 - owner of the read issued in the previous cycle
//   BIOS_ADDR_WIDTH         - default word-address width of the BIOS memory
//   BIOS_DATA_WIDTH         - default read data width
//   BIOS_STARVE_LIMIT       - default fetch starvation bound
//   starve_cnt_width()      - width needed to count 0..limit inclusive
// -----------------------------------------------------------------------------
package bios_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } owner_t;

  localparam int BIOS_ADDR_WIDTH   = 12;
  localparam int BIOS_DATA_WIDTH   = 32;
  localparam int BIOS_STARVE_LIMIT = 4;

  // The counter must be able to hold the limit value itself, hence limit+1.
  function automatic int starve_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/bios_arb_starve_counter.sv
// -----------------------------------------------------------------------------
// bios_arb_starve_counter
// Saturating counter of consecutive denied fetch cycles.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   inc       in   fetch requested but not granted this cycle
//   clr       in   fetch granted, or no fetch request this cycle
//   at_limit  out  counter has reached LIMIT (fetch must win next tie)
// -----------------------------------------------------------------------------
module bios_arb_starve_counter
  import bios_arb_pkg::*;
#(
  parameter int LIMIT = BIOS_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int                 CNT_W     = starve_cnt_width(LIMIT);
  localparam logic [CNT_W-1:0]   LIMIT_VAL = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over increment; the count holds at LIMIT rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LIMIT_VAL)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign at_limit = (r_cnt == LIMIT_VAL);

endmodule

// File: rtl/bios_mem_arbiter.sv
// -----------------------------------------------------------------------------
// bios_mem_arbiter
// Shares the single-ported, synchronous-read BIOS memory between instruction
// fetch and data load. Load normally wins a tie; fetch wins once it has been
// denied STARVE_LIMIT cycles in a row. Read data returns one cycle after the
// grant, qualified by a per-port rvalid.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   if_req/if_addr/if_gnt     fetch request, address, combinational grant
//   if_rvalid/if_rdata        fetch read data valid (registered) and data
//   ld_req/ld_addr/ld_gnt     load request, address, combinational grant
//   ld_rvalid/ld_rdata        load read data valid (registered) and data
//   mem_en/mem_addr           memory read enable and address
//   mem_dout                  memory read data, valid the cycle after mem_en
// -----------------------------------------------------------------------------
module bios_mem_arbiter
  import bios_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = BIOS_ADDR_WIDTH,
  parameter int DATA_WIDTH   = BIOS_DATA_WIDTH,
  parameter int STARVE_LIMIT = BIOS_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  owner_t r_state;
  owner_t w_state_next;
  logic   w_if_gnt;
  logic   w_ld_gnt;
  logic   w_at_limit;
  logic   w_starve_inc;
  logic   w_starve_clr;

  // Owner of the read issued last cycle. An asynchronous reset here is what
  // drops a pending rvalid when reset lands between grant and data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OWN_NONE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant and next-owner logic. Grants are purely a function of the current
  // requests and the starvation flag, so they also follow inputs in reset.
  always_comb begin
    w_if_gnt     = 1'b0;
    w_ld_gnt     = 1'b0;
    w_state_next = OWN_NONE;

    if (ld_req && !(if_req && w_at_limit)) begin
      w_ld_gnt = 1'b1;
    end else if (if_req) begin
      w_if_gnt = 1'b1;
    end

    if (w_ld_gnt) begin
      w_state_next = OWN_LD;
    end else if (w_if_gnt) begin
      w_state_next = OWN_IF;
    end
  end

  // Fetch is "denied" only while it is actually asking; any other cycle
  // (granted or idle) restarts the count.
  assign w_starve_inc = if_req & ~w_if_gnt;
  assign w_starve_clr = ~w_starve_inc;

  bios_arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_starve_inc),
    .clr      (w_starve_clr),
    .at_limit (w_at_limit)
  );

  assign if_gnt    = w_if_gnt;
  assign ld_gnt    = w_ld_gnt;
  assign mem_en    = w_if_gnt | w_ld_gnt;
  // Fetch address is presented when idle so the fetch path sees no extra mux.
  assign mem_addr  = w_ld_gnt ? ld_addr : if_addr;

  assign if_rvalid = (r_state == OWN_IF);
  assign ld_rvalid = (r_state == OWN_LD);
  assign if_rdata  = mem_dout;
  assign ld_rdata  = mem_dout;

endmodule

// File: tb/tb_bios_mem_arbiter.sv
module tb_bios_mem_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LIM = 4;
  localparam logic [DW-1:0] WORD0 = 32'h06400093;
  localparam logic [DW-1:0] WORD1 = 32'h00000597;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] ld_rdata;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;

  logic [DW-1:0] mem_arr [0:(1<<AW)-1];

  int n_checks;
  int n_fail;

  bios_mem_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_gnt    (ld_gnt),
    .ld_rvalid (ld_rvalid),
    .ld_rdata  (ld_rdata),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BIOS memory model.
  always @(posedge clk) begin
    if (mem_en) mem_dout <= mem_arr[mem_addr];
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if ({if_gnt, ld_gnt, if_rvalid, ld_rvalid, mem_en} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got {if_gnt,ld_gnt,if_rv,ld_rv,mem_en}=%b required 00000",
                 c, {if_gnt, ld_gnt, if_rvalid, ld_rvalid, mem_en});
      end
      step();
    end
    $display("test_reset done");
  endtask

  task automatic test_single_fetch();
    step();
    if_req = 1'b1; if_addr = '0;
    #1;
    n_checks++;
    if ({if_gnt, ld_gnt, mem_en} !== 3'b101 || mem_addr !== 12'd0) begin
      n_fail++;
      $display("FAIL fetch_grant: got gnt/en=%b addr=%0d required 101 addr=0",
               {if_gnt, ld_gnt, mem_en}, mem_addr);
    end
    step();
    if_req = 1'b0;
    n_checks++;
    if (if_rvalid !== 1'b1 || ld_rvalid !== 1'b0 || if_rdata !== WORD0) begin
      n_fail++;
      $display("FAIL fetch_data: got if_rv=%b ld_rv=%b data=%h required 1 0 %h",
               if_rvalid, ld_rvalid, if_rdata, WORD0);
    end
    #1;
    n_checks++;
    if (mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_idle_en: got mem_en=%b required 0", mem_en);
    end
    $display("txn fetch addr=0 data=%h", if_rdata);
  endtask

  task automatic test_starvation();
    logic prev_if, prev_ld, exp_if, exp_ld;
    step();
    if_req = 1'b1; ld_req = 1'b1; if_addr = 12'd0; ld_addr = 12'd1;
    prev_if = 1'b0; prev_ld = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) step();
      n_checks++;
      if (if_rvalid !== prev_if || ld_rvalid !== prev_ld ||
          (prev_ld && ld_rdata !== WORD1) || (prev_if && if_rdata !== WORD0)) begin
        n_fail++;
        $display("FAIL starve_rvalid k=%0d: got if_rv=%b ld_rv=%b data=%h required if_rv=%b ld_rv=%b",
                 k, if_rvalid, ld_rvalid, ld_rdata, prev_if, prev_ld);
      end
      exp_if = (k == LIM);
      exp_ld = !exp_if;
      #1;
      n_checks++;
      if (if_gnt !== exp_if || ld_gnt !== exp_ld || mem_addr !== (exp_ld ? 12'd1 : 12'd0)) begin
        n_fail++;
        $display("FAIL starve_grant k=%0d: got if_gnt=%b ld_gnt=%b addr=%0d required %b %b",
                 k, if_gnt, ld_gnt, mem_addr, exp_if, exp_ld);
      end
      $display("txn dual k=%0d granted %s", k, exp_if ? "fetch" : "load");
      prev_if = exp_if; prev_ld = exp_ld;
    end
    step();
    if_req = 1'b0; ld_req = 1'b0;
    n_checks++;
    if (ld_rvalid !== 1'b1 || ld_rdata !== WORD1) begin
      n_fail++;
      $display("FAIL starve_last: got ld_rv=%b data=%h required 1 %h", ld_rvalid, ld_rdata, WORD1);
    end
  endtask

  task automatic test_back_to_back();
    step();
    ld_req = 1'b1; ld_addr = 12'd1;
    #1;
    n_checks++;
    if (ld_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ld_grant: got ld_gnt=%b if_gnt=%b required 1 0", ld_gnt, if_gnt);
    end
    step();
    ld_req = 1'b0; if_req = 1'b1; if_addr = 12'd0;
    n_checks++;
    if (ld_rvalid !== 1'b1 || if_rvalid !== 1'b0 || ld_rdata !== WORD1) begin
      n_fail++;
      $display("FAIL b2b_ld_data: got ld_rv=%b if_rv=%b data=%h required 1 0 %h",
               ld_rvalid, if_rvalid, ld_rdata, WORD1);
    end
    #1;
    n_checks++;
    if (if_gnt !== 1'b1 || ld_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_if_grant: got if_gnt=%b ld_gnt=%b required 1 0", if_gnt, ld_gnt);
    end
    step();
    if_req = 1'b0;
    n_checks++;
    if (if_rvalid !== 1'b1 || ld_rvalid !== 1'b0 || if_rdata !== WORD0) begin
      n_fail++;
      $display("FAIL b2b_if_data: got if_rv=%b ld_rv=%b data=%h required 1 0 %h",
               if_rvalid, ld_rvalid, if_rdata, WORD0);
    end
    step();
    n_checks++;
    if (if_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_quiet: got if_rv=%b ld_rv=%b required 0 0", if_rvalid, ld_rvalid);
    end
    $display("txn load addr=1 then fetch addr=0");
  endtask

  task automatic test_reset_midread();
    logic prev_ld, exp_if, exp_ld;
    // Build up a non-zero starvation count, then reset while a load is live.
    step();
    if_req = 1'b1; ld_req = 1'b1; if_addr = 12'd0; ld_addr = 12'd1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      #1;
      n_checks++;
      if (ld_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL rstmid_pre k=%0d: got ld_gnt=%b required 1", k, ld_gnt);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ld_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got ld_rv=%b if_rv=%b required 0 0", ld_rvalid, if_rvalid);
    end
    step();
    rst = 1'b0;
    n_checks++;
    if (ld_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_drop_ld: got ld_rv=%b if_rv=%b required 0 0", ld_rvalid, if_rvalid);
    end
    // A cleared counter means four full load wins before fetch gets in.
    prev_ld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      n_checks++;
      if (ld_rvalid !== prev_ld) begin
        n_fail++;
        $display("FAIL rstmid_rv k=%0d: got ld_rv=%b required %b", k, ld_rvalid, prev_ld);
      end
      exp_if = (k == LIM);
      exp_ld = !exp_if;
      #1;
      n_checks++;
      if (if_gnt !== exp_if || ld_gnt !== exp_ld) begin
        n_fail++;
        $display("FAIL rstmid_cnt k=%0d: got if_gnt=%b ld_gnt=%b required %b %b",
                 k, if_gnt, ld_gnt, exp_if, exp_ld);
      end
      prev_ld = exp_ld;
    end
    step();
    ld_req = 1'b0; if_req = 1'b0;
    // Grant a fetch, then reset before its data edge.
    step();
    if_req = 1'b1; if_addr = 12'd0;
    #1;
    n_checks++;
    if (if_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_if_gnt: got if_gnt=%b required 1", if_gnt);
    end
    #1;
    rst = 1'b1;
    step();
    rst = 1'b0; if_req = 1'b0;
    n_checks++;
    if (if_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_drop_if: got if_rv=%b required 0", if_rvalid);
    end
    step();
    n_checks++;
    if (if_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_late_if: got if_rv=%b required 0", if_rvalid);
    end
    // Normal service afterwards.
    if_req = 1'b1; if_addr = 12'd1;
    #1;
    n_checks++;
    if (if_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_after_gnt: got if_gnt=%b required 1", if_gnt);
    end
    step();
    if_req = 1'b0;
    n_checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== WORD1) begin
      n_fail++;
      $display("FAIL rstmid_after_data: got if_rv=%b data=%h required 1 %h", if_rvalid, if_rdata, WORD1);
    end
    $display("txn reset mid-read recovered");
  endtask

  task automatic test_random();
    int            deny_run;
    int            obs_run;
    logic          exp_if, exp_ld, prev_if, prev_ld;
    logic [DW-1:0] prev_data;
    step();
    deny_run = 0; obs_run = 0;
    prev_if = 1'b0; prev_ld = 1'b0; prev_data = '0;
    for (int i = 0; i <= 1000; i++) begin
      if (i > 0) step();
      n_checks++;
      if (if_rvalid !== prev_if || ld_rvalid !== prev_ld ||
          (prev_if && if_rdata !== prev_data) || (prev_ld && ld_rdata !== prev_data)) begin
        n_fail++;
        $display("FAIL rand_rdata i=%0d: got if_rv=%b ld_rv=%b data=%h required if_rv=%b ld_rv=%b data=%h",
                 i, if_rvalid, ld_rvalid, mem_dout, prev_if, prev_ld, prev_data);
      end
      if (i == 1000) break;
      if_req  = ($urandom_range(0, 3) != 0);
      ld_req  = ($urandom_range(0, 3) != 0);
      if_addr = ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom_range(0, (1<<AW)-1));
      ld_addr = ($urandom_range(0, 3) == 0) ? AW'(1) : AW'($urandom_range(0, (1<<AW)-1));
      #1;
      // Load wins ties unless fetch has already lost LIM times in a row.
      exp_ld = ld_req && !(if_req && deny_run >= LIM);
      exp_if = if_req && !exp_ld;
      n_checks++;
      if (if_gnt !== exp_if || ld_gnt !== exp_ld || mem_en !== (exp_if | exp_ld) ||
          mem_addr !== (exp_ld ? ld_addr : if_addr)) begin
        n_fail++;
        $display("FAIL rand_grant i=%0d: got if_gnt=%b ld_gnt=%b en=%b addr=%h required %b %b %b %h",
                 i, if_gnt, ld_gnt, mem_en, mem_addr, exp_if, exp_ld, exp_if | exp_ld,
                 exp_ld ? ld_addr : if_addr);
      end
      n_checks++;
      if (if_gnt === 1'b1 && ld_gnt === 1'b1) begin
        n_fail++;
        $display("FAIL rand_exclusive i=%0d: got both grants required at most one", i);
      end
      obs_run = (if_req && if_gnt !== 1'b1) ? obs_run + 1 : 0;
      n_checks++;
      if (obs_run > LIM) begin
        n_fail++;
        $display("FAIL rand_starve i=%0d: got %0d consecutive fetch denials required <= %0d", i, obs_run, LIM);
      end
      $display("txn %0d: if_req=%b ld_req=%b -> %s", i, if_req, ld_req,
               exp_ld ? "load" : (exp_if ? "fetch" : "none"));
      deny_run  = (if_req && !exp_if) ? ((deny_run < LIM) ? deny_run + 1 : LIM) : 0;
      prev_if   = exp_if;
      prev_ld   = exp_ld;
      prev_data = exp_ld ? mem_arr[ld_addr] : mem_arr[if_addr];
    end
    if_req = 1'b0; ld_req = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < (1<<AW); i++) mem_arr[i] = $urandom;
    mem_arr[0] = WORD0;
    mem_arr[1] = WORD1;
    mem_dout = '0;
    rst      = 1'b1;
    if_req   = 1'b0;
    ld_req   = 1'b0;
    if_addr  = '0;
    ld_addr  = '0;
    repeat (3) @(posedge clk);

    test_reset();
    test_single_fetch();
    test_starvation();
    test_back_to_back();
    test_reset_midread();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bios_mem_arbiter.md
# bios_mem_arbiter

Shares the single-ported, synchronous-read BIOS memory between the CPU's instruction-fetch path and its data-load path. Each cycle it grants the memory to at most one requester and tags the outstanding read with its owner. It returns the read data one cycle later with a per-port valid. A starvation counter bounds how long fetch can be locked out by back-to-back loads. It sits between the Riscv151 pipeline and the `bios_mem` instance.

## Interface
- `ADDR_WIDTH`, default 12: word-address width of the BIOS memory.
- `DATA_WIDTH`, default 32: read data width.
- `STARVE_LIMIT`, default 4: number of consecutive denied fetch cycles after which fetch gets priority. Must be ≥1.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `if_req`  in  1  fetch read request; held with `if_addr` until granted.
- `if_addr`  in  ADDR_WIDTH  fetch word address.
- `if_gnt`  out  1  combinational; fetch request accepted this cycle.
- `if_rvalid`  out  1  registered; `if_rdata` valid this cycle.
- `if_rdata`  out  DATA_WIDTH  read data for fetch; equals `mem_dout`.
- `ld_req`  in  1  load read request; held with `ld_addr` until granted.
- `ld_addr`  in  ADDR_WIDTH  load word address.
- `ld_gnt`  out  1  combinational; load request accepted this cycle.
- `ld_rvalid`  out  1  registered; `ld_rdata` valid this cycle.
- `ld_rdata`  out  DATA_WIDTH  read data for load; equals `mem_dout`.
- `mem_en`  out  1  memory read enable.
- `mem_addr`  out  ADDR_WIDTH  memory address; the granted requester's address.
- `mem_dout`  in  DATA_WIDTH  memory read data, valid the cycle after `mem_en`.

## Operation
- **Owner FSM.** States IDLE, RD_IF and RD_LD record the owner of the read issued in the previous cycle.
  - Next state is RD_LD if `ld_gnt`, RD_IF if `if_gnt`, otherwise IDLE.
  - `if_rvalid` = (state==RD_IF). `ld_rvalid` = (state==RD_LD).
- **Grant rule (combinational).**
  - Only `ld_req`: `ld_gnt`=1.
  - Only `if_req`: `if_gnt`=1.
  - Both: `ld_gnt`=1, unless `starve_cnt`==STARVE_LIMIT, in which case `if_gnt`=1.
  - Neither: no grant, `mem_en`=0.
  - `if_gnt` and `ld_gnt` are never both 1.
- `mem_en` = `if_gnt`|`ld_gnt`. `mem_addr` is the granted address, or `if_addr` when idle.
- **Starvation counter.** Width `$clog2(STARVE_LIMIT+1)`.
  - Increments when `if_req` & !`if_gnt`.
  - Clears to 0 when `if_gnt`, or when `if_req`=0.
  - Saturates at STARVE_LIMIT and never wraps.
- Both rdata ports are wired directly to `mem_dout`. A consumer must qualify them with its rvalid.
- A requester that drops its req before it is granted is legal; nothing is issued for it.

## Timing
- Reset values: state IDLE, `starve_cnt`=0, `if_rvalid`=0, `ld_rvalid`=0. Grants follow inputs combinationally even during reset; the memory output is ignored because no rvalid is raised.
- Latency: grant in cycle N gives rvalid and data in cycle N+1, for either port.
- Throughput: one grant per cycle, and back-to-back reads are sustained.
- Reset asserted mid-read: the pending rvalid is dropped and never issued. The first grant after `rst` deasserts behaves as from IDLE.
- Simultaneous requests at the limit: fetch wins, the counter clears in the same edge, and load wins the next cycle if it is still requesting.
- With `STARVE_LIMIT`=1, sustained dual requests alternate load/fetch every cycle, starting with load.

## Structure
- Shared package `bios_arb_pkg`:
  - owner enum `{OWN_NONE, OWN_IF, OWN_LD}`
  - default `ADDR_WIDTH`/`DATA_WIDTH` localparams
- The natural sub-module is `bios_arb_starve_counter`: the saturating counter, with inputs inc/clr and output `at_limit`. The FSM and grant logic stay in the top module.

## Test plan
Memory preloaded with word 0 = 32'h06400093 and word 1 = 32'h00000597; `STARVE_LIMIT`=4.
1. Reset released, no requests → all outputs 0, `mem_en`=0 for 5 cycles.
2. `if_req`=1, `if_addr`=0 for one cycle → `if_gnt`=1 that cycle; next cycle `if_rvalid`=1, `if_rdata`=32'h06400093, `ld_rvalid`=0.
3. `if_req`, `ld_req` both held with `ld_addr`=1 → `ld_gnt` on 4 consecutive cycles, each followed by `ld_rvalid` with 32'h00000597. Cycle 5 gives `if_gnt`, then `ld_gnt` resumes.
4. Load alone with `ld_addr`=1, then fetch alone with `if_addr`=0 in the next cycle → `ld_rvalid`, then `if_rvalid` in consecutive cycles with the correct words; no overlap.
5. Grant fetch, then assert `rst` for 1 cycle before the rvalid edge → `if_rvalid` never asserts, `starve_cnt`=0, and the next request is serviced normally.
6. Random req/addr for 1000 cycles against a reference model → grants are never simultaneous, every grant yields exactly one rvalid with matching data, and fetch is never denied more than 4 consecutive cycles.
